// File: rtl/universal_reg_bank.sv
// WIDTH-bit general-purpose register with complementary outputs, clock enable,
// synchronous reset and eight registered modes (hold/load/shift/rotate/toggle/clear).
module universal_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero
);

    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
            $error("universal_reg_bank: WIDTH must be in 2..64");
        end
    endgenerate

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHL    = 3'b010;
    localparam logic [2:0] MODE_SHR    = 3'b011;
    localparam logic [2:0] MODE_ROTL   = 3'b100;
    localparam logic [2:0] MODE_ROTR   = 3'b101;
    localparam logic [2:0] MODE_TOGGLE = 3'b110;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             zero_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD:   q_d = q_q;
                MODE_LOAD:   q_d = d;
                MODE_SHL:    q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_SHR:    q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_ROTL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROTR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_TOGGLE: q_d = ~q_q;
                MODE_CLEAR:  q_d = RESET_VAL;
                default:     q_d = q_q;
            endcase
        end
    end

    // zero is derived from next-q so it lands on the same edge as q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            zero_q <= (RESET_VAL == '0);
        end else begin
            q_q    <= q_d;
            zero_q <= (q_d == '0);
        end
    end

    assign q      = q_q;
    assign qn     = ~q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign zero   = zero_q;

endmodule

// File: tb/tb_universal_reg_bank.sv
// Directed bench for universal_reg_bank: three instances (8-bit with RESET_VAL=A5,
// 8-bit with RESET_VAL=0, 2-bit) driven by a linear sequence of steps.
module tb_universal_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passes = 0;

    // Instance A: WIDTH=8, RESET_VAL=8'hA5
    logic       rst_a, en_a, sl_a, sr_a;
    logic [2:0] mode_a;
    logic [7:0] d_a, q_a, qn_a;
    logic       soutl_a, soutr_a, zero_a;

    // Instance Z: WIDTH=8, RESET_VAL=0
    logic       rst_z, en_z, sl_z, sr_z;
    logic [2:0] mode_z;
    logic [7:0] d_z, q_z, qn_z;
    logic       soutl_z, soutr_z, zero_z;

    // Instance W: WIDTH=2, RESET_VAL=0
    logic       rst_w, en_w, sl_w, sr_w;
    logic [2:0] mode_w;
    logic [1:0] d_w, q_w, qn_w;
    logic       soutl_w, soutr_w, zero_w;

    universal_reg_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .d(d_a),
        .sin_l(sl_a), .sin_r(sr_a), .q(q_a), .qn(qn_a),
        .sout_l(soutl_a), .sout_r(soutr_a), .zero(zero_a)
    );

    universal_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00)) u_z (
        .clk(clk), .rst(rst_z), .en(en_z), .mode(mode_z), .d(d_z),
        .sin_l(sl_z), .sin_r(sr_z), .q(q_z), .qn(qn_z),
        .sout_l(soutl_z), .sout_r(soutr_z), .zero(zero_z)
    );

    universal_reg_bank #(.WIDTH(2), .RESET_VAL(2'b00)) u_w (
        .clk(clk), .rst(rst_w), .en(en_w), .mode(mode_w), .d(d_w),
        .sin_l(sl_w), .sin_r(sr_w), .q(q_w), .qn(qn_w),
        .sout_l(soutl_w), .sout_r(soutr_w), .zero(zero_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic e, input logic [2:0] m,
                           input logic [7:0] dd, input logic l, input logic rr);
        rst_a = r; en_a = e; mode_a = m; d_a = dd; sl_a = l; sr_a = rr;
        tick();
    endtask

    task automatic drive_z(input logic r, input logic e, input logic [2:0] m,
                           input logic [7:0] dd);
        rst_z = r; en_z = e; mode_z = m; d_z = dd; sl_z = 1'b0; sr_z = 1'b0;
        tick();
    endtask

    task automatic drive_w(input logic r, input logic e, input logic [2:0] m,
                           input logic [1:0] dd, input logic l, input logic rr);
        rst_w = r; en_w = e; mode_w = m; d_w = dd; sl_w = l; sr_w = rr;
        tick();
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; mode_a = 3'b000; d_a = 8'h00; sl_a = 1'b0; sr_a = 1'b0;
        rst_z = 1'b0; en_z = 1'b0; mode_z = 3'b000; d_z = 8'h00; sl_z = 1'b0; sr_z = 1'b0;
        rst_w = 1'b0; en_w = 1'b0; mode_w = 3'b000; d_w = 2'b00; sl_w = 1'b0; sr_w = 1'b0;
        #2;

        // Reset and complement outputs
        rst_z = 1'b1; rst_w = 1'b1;
        drive_a(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
        check("rst_q",      q_a, 8'hA5);
        check("rst_qn",     qn_a, 8'h5A);
        check("rst_sout_l", soutl_a, 1'b1);
        check("rst_sout_r", soutr_a, 1'b1);
        check("rst_zero",   zero_a, 1'b0);
        check("rst_z_q",    q_z, 8'h00);
        check("rst_z_zero", zero_z, 1'b1);
        check("rst_w_q",    q_w, 2'b00);
        check("rst_w_zero", zero_w, 1'b1);
        rst_z = 1'b0; rst_w = 1'b0;

        // Load, then enable gating holds q
        drive_a(1'b0, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
        check("load_3c", q_a, 8'h3C);
        check("load_qn", qn_a, 8'hC3);
        for (int i = 0; i < 3; i++) drive_a(1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0);
        check("en0_hold", q_a, 8'h3C);
        drive_a(1'b0, 1'b1, 3'b000, 8'hFF, 1'b0, 1'b0);
        check("mode_hold", q_a, 8'h3C);

        // Serial shift left stream 1,0,1,1 then shift right with sin_r=1
        drive_a(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        check("load_00_zero", zero_a, 1'b1);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("shl_1", q_a, 8'h01);
        check("shl_1_zero", zero_a, 1'b0);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
        check("shl_2", q_a, 8'h02);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("shl_3", q_a, 8'h05);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("shl_4", q_a, 8'h0B);
        drive_a(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
        check("shr_q",      q_a, 8'h85);
        check("shr_sout_r", soutr_a, 1'b1);
        check("shr_sout_l", soutl_a, 1'b1);

        // Rotate wrap-around
        drive_a(1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
        drive_a(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
        check("rotl_81", q_a, 8'h03);
        drive_a(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        check("rotr_03", q_a, 8'h81);
        drive_a(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        check("rotr_81", q_a, 8'hC0);
        drive_a(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
        check("rotr_c0", q_a, 8'h60);

        // Toggle and zero flag on the same edge
        drive_a(1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
        drive_a(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        check("tog_ff_q",    q_a, 8'h00);
        check("tog_ff_zero", zero_a, 1'b1);
        check("tog_ff_qn",   qn_a, 8'hFF);
        drive_a(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        check("tog_00_q",    q_a, 8'hFF);
        check("tog_00_zero", zero_a, 1'b0);

        // Clear loads RESET_VAL
        drive_a(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        check("clr_a_q",    q_a, 8'hA5);
        check("clr_a_zero", zero_a, 1'b0);
        drive_z(1'b0, 1'b1, 3'b001, 8'h5A);
        check("z_load", q_z, 8'h5A);
        check("z_load_zero", zero_z, 1'b0);
        drive_z(1'b0, 1'b1, 3'b111, 8'hFF);
        check("z_clr_q",    q_z, 8'h00);
        check("z_clr_zero", zero_z, 1'b1);

        // Reset overrides a shift in progress, then shifting resumes from RESET_VAL
        drive_a(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("pre_rst_shl", q_a, 8'h01);
        drive_a(1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("mid_rst_q",    q_a, 8'hA5);
        check("mid_rst_zero", zero_a, 1'b0);
        drive_a(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
        check("post_rst_shl", q_a, 8'h4B);

        // WIDTH=2 degenerate slices
        drive_w(1'b0, 1'b1, 3'b001, 2'b10, 1'b0, 1'b0);
        check("w_load", q_w, 2'b10);
        drive_w(1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0);
        check("w_rotl",   q_w, 2'b01);
        check("w_qn",     qn_w, 2'b10);
        check("w_sout_r", soutr_w, 1'b1);
        drive_w(1'b0, 1'b1, 3'b101, 2'b00, 1'b0, 1'b0);
        check("w_rotr",   q_w, 2'b10);
        check("w_sout_l", soutl_w, 1'b1);
        drive_w(1'b0, 1'b1, 3'b010, 2'b00, 1'b1, 1'b0);
        check("w_shl", q_w, 2'b01);
        drive_w(1'b0, 1'b1, 3'b011, 2'b00, 1'b0, 1'b1);
        check("w_shr", q_w, 2'b10);
        drive_w(1'b0, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0);
        drive_w(1'b0, 1'b1, 3'b011, 2'b00, 1'b0, 1'b0);
        check("w_shr_zero_q",    q_w, 2'b00);
        check("w_shr_zero_flag", zero_w, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
